axi_stim_sequencer: RTL and testbench
=====================================

Name: axi_stim_sequencer

Overview: Parametrised, table-driven AXI4 master that replays a compile-time list of single-beat write/read commands into an xbar slave port, one command at a time, with a fixed inter-command gap. Replaces hand-coded cycle-count stimulus in simulation tops; reports completion, sticky error status and the last read data.

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width (multiple of 8)
ID_WIDTH, 4, AXI ID width; all IDs driven 0
NUM_CMDS, 3, command table depth (>=1)
GAP_CYCLES, 10, idle cycles before each command (0 allowed)
CMD_ADDR, '0, packed [NUM_CMDS-1:0][ADDR_WIDTH-1:0] per-command address, index 0 first
CMD_DATA, '0, packed [NUM_CMDS-1:0][DATA_WIDTH-1:0] write data / expected read data
CMD_READ, '0, [NUM_CMDS-1:0] bit i=1: command i is a read, else a write

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
start_i  input  1  pulse; starts the sequence from IDLE or DONE
done_o  output  1  sequence complete; held until next start
err_o  output  1  sticky: non-OKAY response (or mismatch, see feature)
rdata_o  output  DATA_WIDTH  data of last completed read
aw_valid_o  output  1  write address valid
aw_ready_i  input  1  write address ready
aw_addr_o  output  ADDR_WIDTH  write address
aw_id_o  output  ID_WIDTH  write ID, constant 0
w_valid_o  output  1  write data valid
w_ready_i  input  1  write data ready
w_data_o  output  DATA_WIDTH  write data
w_strb_o  output  DATA_WIDTH/8  write strobe, constant all ones
w_last_o  output  1  constant 1 (single beat)
b_valid_i  input  1  write response valid
b_ready_o  output  1  write response ready
b_resp_i  input  2  write response
ar_valid_o  output  1  read address valid
ar_ready_i  input  1  read address ready
ar_addr_o  output  ADDR_WIDTH  read address
ar_id_o  output  ID_WIDTH  read ID, constant 0
r_valid_i  input  1  read data valid
r_ready_o  output  1  read data ready
r_data_i  input  DATA_WIDTH  read data
r_resp_i  input  2  read response

Behaviour:
- One clock, clk_i; reset synchronous active-low on rst_ni. Reset (including mid-handshake): state IDLE, idx 0, all valids/readies 0, done_o 0, err_o 0, rdata_o 0, addr/data outputs 0. Valids drop at the reset edge even if not accepted.
- States: IDLE, GAP, WR, WRESP, RD, RDATA, DONE. All outputs registered.
- start_i in IDLE/DONE: idx<-0, done_o<-0, err_o<-0, gap counter<-GAP_CYCLES, go GAP. start_i in any other state is ignored.
- GAP: counter decrements each cycle. At 0, load the addr/data of CMD_ADDR[idx]/CMD_DATA[idx] and go WR (assert aw_valid_o, w_valid_o) or RD (assert ar_valid_o) per CMD_READ[idx]. First valid appears GAP_CYCLES+1 cycles after the start_i edge.
- WR: AW and W complete independently, in either order or in the same cycle. Each valid deasserts the cycle after its own handshake and never before it. Payload is stable while valid. When both are done, go WRESP with b_ready_o=1.
- WRESP: on b_valid_i, b_ready_o<-0 and err_o|=(b_resp_i!=0).
- RD: ar_valid_o is held until ar_ready_i, then go RDATA with r_ready_o=1.
- RDATA: on r_valid_i, rdata_o<-r_data_i, err_o|=(r_resp_i!=0), r_ready_o<-0.
- After each response: if idx==NUM_CMDS-1, go DONE (done_o=1); else idx++, counter<-GAP_CYCLES, go GAP. idx width is max(1,$clog2(NUM_CMDS)).
- b_valid_i/r_valid_i outside WRESP/RDATA are ignored (ready low). Error does not abort the sequence.

Optional Feature:
- AXI_STIM_CHECK_EN defined: in RDATA, err_o also sets when r_data_i!=CMD_DATA[idx].
- AXI_STIM_CHECK_EN not defined: reads only capture data into rdata_o; no compare logic is built.

Test Plan:
- NUM_CMDS=3 writes (0x5000_0010<-0x9000_0004, 0x5000_0020<-0x2424_4242, 0x5000_0028<-0x1), GAP 10, always-ready slave -> three AW/W handshakes each 11 cycles after the previous response, done_o=1, err_o=0.
- AW ready 3 cycles before W ready, then W ready 3 cycles before AW ready, then both in the same cycle -> each valid drops the cycle after its own handshake, payload stable throughout, exactly one B accepted per write.
- Read command at 0x9000_0004 with memory returning 0xABCD and r_resp=0 -> rdata_o=0xABCD. With the macro and CMD_DATA=0x1234 -> err_o=1. Without the macro -> err_o=0.
- b_resp=2'b10 on command 0 -> err_o=1 and stays set; commands 1-2 still issue; done_o=1. A second start_i clears err_o.
- rst_ni low for one cycle while aw_valid_o=1 and aw_ready_i=0 -> all valids 0 next cycle, state IDLE; GAP_CYCLES=0 with a subsequent start_i -> aw_valid_o asserted one cycle after start.

Source files
------------

// File: rtl/axi_stim_sequencer.sv
// axi_stim_sequencer: table-driven single-beat AXI4 master.
// Replays NUM_CMDS write/read commands one at a time. Each command waits
// GAP_CYCLES idle cycles first. The master reports completion, a sticky
// error flag and the data of the last completed read.
// Optional macro AXI_STIM_CHECK_EN: read data is compared against
// CMD_DATA[idx], and a mismatch also sets err_o.
module axi_stim_sequencer #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned NUM_CMDS   = 3,
  parameter int unsigned GAP_CYCLES = 10,
  parameter logic [NUM_CMDS-1:0][ADDR_WIDTH-1:0] CMD_ADDR = '0,
  parameter logic [NUM_CMDS-1:0][DATA_WIDTH-1:0] CMD_DATA = '0,
  parameter logic [NUM_CMDS-1:0]                 CMD_READ = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    done_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [ID_WIDTH-1:0]     ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i
);

  localparam int unsigned IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_WR    = 3'd2,
    S_WRESP = 3'd3,
    S_RD    = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e                state_q,    state_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q,  w_valid_d;
  logic                  b_ready_q,  b_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q,  r_ready_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic                  rd_err;

  // Read response error: a non-OKAY response, plus a data mismatch when checking is built in.
  always_comb begin
`ifdef AXI_STIM_CHECK_EN
    rd_err = (r_resp_i != 2'b00) || (r_data_i != CMD_DATA[idx_q]);
`else
    rd_err = (r_resp_i != 2'b00);
`endif
  end

  // Next-state and next-output logic of the command sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    done_d     = done_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          state_d = state_q;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          addr_d = CMD_ADDR[idx_q];
          if (CMD_READ[idx_q]) begin
            ar_valid_d = 1'b1;
            state_d    = S_RD;
          end else begin
            wdata_d    = CMD_DATA[idx_q];
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = S_WR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR: begin
        // AW and W retire independently; each valid drops after its own handshake.
        aw_valid_d = aw_valid_q & ~aw_ready_i;
        w_valid_d  = w_valid_q & ~w_ready_i;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WRESP;
        end else begin
          state_d = S_WR;
        end
      end
      S_WRESP: begin
        if (b_valid_i) begin
          b_ready_d = 1'b0;
          err_d     = err_q | (b_resp_i != 2'b00);
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end else begin
          state_d = S_WRESP;
        end
      end
      S_RD: begin
        if (ar_ready_i) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RDATA;
        end else begin
          state_d = S_RD;
        end
      end
      S_RDATA: begin
        if (r_valid_i) begin
          r_ready_d = 1'b0;
          rdata_d   = r_data_i;
          err_d     = err_q | rd_err;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end else begin
          state_d = S_RDATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; the reset drops every valid immediately.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign aw_valid_o = aw_valid_q;
  assign aw_addr_o  = addr_q;
  assign aw_id_o    = {ID_WIDTH{1'b0}};
  assign w_valid_o  = w_valid_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = {(DATA_WIDTH/8){1'b1}};
  assign w_last_o   = 1'b1;
  assign b_ready_o  = b_ready_q;
  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = addr_q;
  assign ar_id_o    = {ID_WIDTH{1'b0}};
  assign r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_axi_stim_sequencer.sv
// Testbench for axi_stim_sequencer.
// A per-command table holds the slave behaviour and the expected master
// outputs. Hand-written sequences cover reset during a handshake and
// the GAP_CYCLES=0 case.
module tb_axi_stim_sequencer;
  localparam int GAP = 10;
`ifdef AXI_STIM_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [63:0] r_data;
  logic done, err, aw_valid, w_valid, b_ready, ar_valid, r_ready, w_last;
  logic [63:0] rdata, aw_addr, w_data, ar_addr;
  logic [3:0] aw_id, ar_id;
  logic [7:0] w_strb;

  axi_stim_sequencer #(
    .NUM_CMDS(4), .GAP_CYCLES(GAP),
    .CMD_ADDR({64'h0000_0000_9000_0004, 64'h0000_0000_5000_0028,
               64'h0000_0000_5000_0020, 64'h0000_0000_5000_0010}),
    .CMD_DATA({64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001,
               64'h0000_0000_2424_4242, 64'h0000_0000_9000_0004}),
    .CMD_READ(4'b1000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .done_o(done), .err_o(err),
    .rdata_o(rdata), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .aw_addr_o(aw_addr), .aw_id_o(aw_id), .w_valid_o(w_valid),
    .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .w_last_o(w_last), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .b_resp_i(b_resp), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .ar_addr_o(ar_addr), .ar_id_o(ar_id), .r_valid_i(r_valid),
    .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp)
  );

  // Second instance: GAP_CYCLES=0 with a single write and a silent slave.
  logic start2;
  logic tie0 = 1'b0;
  logic [1:0] tie2 = 2'b00;
  logic [63:0] tie64 = 64'h0;
  logic done2, err2, aw_valid2, w_valid2, b_ready2, ar_valid2, r_ready2, w_last2;
  logic [63:0] rdata2, aw_addr2, w_data2, ar_addr2;
  logic [3:0] aw_id2, ar_id2;
  logic [7:0] w_strb2;

  axi_stim_sequencer #(
    .NUM_CMDS(1), .GAP_CYCLES(0),
    .CMD_ADDR(64'h0000_0000_0000_0040), .CMD_DATA(64'h0000_0000_0000_0055),
    .CMD_READ(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .done_o(done2), .err_o(err2),
    .rdata_o(rdata2), .aw_valid_o(aw_valid2), .aw_ready_i(tie0),
    .aw_addr_o(aw_addr2), .aw_id_o(aw_id2), .w_valid_o(w_valid2),
    .w_ready_i(tie0), .w_data_o(w_data2), .w_strb_o(w_strb2),
    .w_last_o(w_last2), .b_valid_i(tie0), .b_ready_o(b_ready2),
    .b_resp_i(tie2), .ar_valid_o(ar_valid2), .ar_ready_i(tie0),
    .ar_addr_o(ar_addr2), .ar_id_o(ar_id2), .r_valid_i(tie0),
    .r_ready_o(r_ready2), .r_data_i(tie64), .r_resp_i(tie2)
  );

  typedef struct {
    logic [63:0] addr;    // expected address
    logic [63:0] data;    // expected write data
    logic        is_rd;   // expected command kind
    int          aw_dly;  // cycles before aw_ready (ar_ready for reads)
    int          w_dly;   // cycles before w_ready
    logic [1:0]  resp;    // B/R response returned by the slave
    logic [63:0] rdata;   // read data returned (and expected on rdata_o)
    logic        exp_err; // expected err_o after the response
  } vec_t;

  vec_t tab [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v, input int c0, input logic is_last, output int c_next);
    int cyc;
    int k;
    bit awd;
    bit wd;
    cyc = c0;
    while (!(aw_valid || ar_valid) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("gap_cycles", 64'(cyc), 64'(GAP + 1));
    if (!v.is_rd) begin
      awd = 1'b0; wd = 1'b0; k = 0;
      while (!(awd && wd) && k < 20) begin
        chk("aw_valid", aw_valid, !awd);
        chk("w_valid", w_valid, !wd);
        if (!awd) chk("aw_addr", aw_addr, v.addr);
        if (!wd) begin
          chk("w_data", w_data, v.data);
          chk("w_strb_last", {w_strb, w_last}, 9'h1FF);
        end
        aw_ready = !awd && (k >= v.aw_dly);
        w_ready  = !wd && (k >= v.w_dly);
        @(posedge clk); #1;
        if (aw_ready) awd = 1'b1;
        if (w_ready) wd = 1'b1;
        k++;
      end
      aw_ready = 1'b0; w_ready = 1'b0;
      chk("aw_valid_after", aw_valid, 1'b0);
      chk("w_valid_after", w_valid, 1'b0);
      chk("b_ready", b_ready, 1'b1);
      b_valid = 1'b1; b_resp = v.resp;
      @(posedge clk); #1;
      chk("b_ready_drop", b_ready, 1'b0);
      chk("done", done, is_last);
      chk("err", err, v.exp_err);
      // Keep B valid one more cycle: it must not be accepted again.
      @(posedge clk); #1;
      b_valid = 1'b0; b_resp = 2'b00;
      chk("b_ready_once", b_ready, 1'b0);
      chk("done_hold", done, is_last);
      c_next = 1;
    end else begin
      chk("ar_addr", ar_addr, v.addr);
      chk("ar_id", ar_id, 4'h0);
      for (int i = 0; i < v.aw_dly; i++) begin
        @(posedge clk); #1;
        chk("ar_hold", ar_valid, 1'b1);
        chk("ar_addr_stable", ar_addr, v.addr);
      end
      ar_ready = 1'b1;
      @(posedge clk); #1;
      ar_ready = 1'b0;
      chk("ar_valid_after", ar_valid, 1'b0);
      chk("r_ready", r_ready, 1'b1);
      r_valid = 1'b1; r_data = v.rdata; r_resp = v.resp;
      @(posedge clk); #1;
      r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00;
      chk("r_ready_drop", r_ready, 1'b0);
      chk("rdata", rdata, v.rdata);
      chk("done", done, is_last);
      chk("err", err, v.exp_err);
      c_next = 0;
    end
  endtask

  initial begin
    int c;
    int seen;
    // Run 1: always-ready slave, OKAY everywhere, read returns 0xABCD.
    tab[0] = '{64'h5000_0010, 64'h9000_0004, 1'b0, 0, 0, 2'b00, 64'h0, 1'b0};
    tab[1] = '{64'h5000_0020, 64'h2424_4242, 1'b0, 0, 0, 2'b00, 64'h0, 1'b0};
    tab[2] = '{64'h5000_0028, 64'h1,         1'b0, 0, 0, 2'b00, 64'h0, 1'b0};
    tab[3] = '{64'h9000_0004, 64'h0,         1'b1, 0, 0, 2'b00, 64'hABCD, CHK};
    // Run 2: skewed AW/W handshakes, SLVERR on command 0, matching read data.
    tab[4] = '{64'h5000_0010, 64'h9000_0004, 1'b0, 0, 3, 2'b10, 64'h0, 1'b1};
    tab[5] = '{64'h5000_0020, 64'h2424_4242, 1'b0, 3, 0, 2'b00, 64'h0, 1'b1};
    tab[6] = '{64'h5000_0028, 64'h1,         1'b0, 1, 1, 2'b00, 64'h0, 1'b1};
    tab[7] = '{64'h9000_0004, 64'h0,         1'b1, 2, 0, 2'b00, 64'h1234, 1'b1};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 5'b0);
    chk("rst_done_err", {done, err}, 2'b0);
    chk("rst_rdata", rdata, 64'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 2; r++) begin
      pulse_start();
      chk("start_clears", {done, err}, 2'b00);
      c = 0;
      for (int i = 0; i < 4; i++) run_cmd(tab[r * 4 + i], c, (i == 3), c);
    end

    // Run 3: start clears sticky error, then reset in the middle of an AW handshake.
    pulse_start();
    chk("restart_clears", {done, err}, 2'b00);
    c = 0;
    while (!aw_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("gap_cycles_r3", 64'(c), 64'(GAP + 1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 5'b0);
    chk("midrst_flags", {done, err}, 2'b00);
    chk("midrst_rdata", rdata, 64'h0);
    chk("midrst_addr", aw_addr, 64'h0);
    chk("midrst_wdata", w_data, 64'h0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (aw_valid || w_valid || ar_valid) seen++;
    end
    chk("idle_after_rst", 64'(seen), 64'h0);

    // GAP_CYCLES=0: valid appears one cycle after the start edge.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("gap0_at_start", aw_valid2, 1'b0);
    @(posedge clk); #1;
    chk("gap0_valids", {aw_valid2, w_valid2}, 2'b11);
    chk("gap0_addr", aw_addr2, 64'h40);
    chk("gap0_data", w_data2, 64'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
